// File: rtl/nano_mem_arbiter_pkg.sv
// Shared types, widths and small helpers for the program/data memory arbiter.
package nano_arb_pkg;

  typedef enum logic [0:0] {
    sIDLE = 1'b0,
    sHOLD = 1'b1
  } arbStateType;

  localparam int ARB_ADDR_W = 8;
  localparam int ARB_DATA_W = 16;
  localparam int ARB_CNT_W  = 4;

  // Saturating increment of the ownership run counter.
  function automatic logic [ARB_CNT_W-1:0] sat_inc(input logic [ARB_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Next requester index, wrapping at n.
  function automatic logic [1:0] next_idx(input logic [1:0] i, input int n);
    int t;
    t = int'(i) + 1;
    if (t >= n) t = 0;
    return t[1:0];
  endfunction

endpackage

// File: rtl/nano_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from start,
// optionally skipping one index.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   start,
  input  logic         excl_en,
  input  logic [1:0]   excl_idx,
  output logic         found,
  output logic [1:0]   idx
);

  always_comb begin
    int c;
    // NOTE: every output gets a default before the loop so no latch is inferred.
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(start) + k) % N;
      if (!found && req[c] && !(excl_en && c == int'(excl_idx))) begin
        found = 1'b1;
        idx   = c[1:0];
      end
    end
  end

endmodule

// File: rtl/nano_mem_arbiter.sv
// Arbiter sharing the single-port 256x16 memory between up to four masters,
// with quantum-limited ownership and round-robin rotation.
module nano_mem_arbiter
  import nano_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int QUANTUM = 4,
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        we_i,
  input  logic [N_REQ*ADDR_W-1:0] addr_i,
  input  logic [N_REQ*DATA_W-1:0] wdata_i,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    mem_ce,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_address,
  output logic [DATA_W-1:0]       mem_dataW,
  input  logic [DATA_W-1:0]       mem_dataR,
  output logic [1:0]              owner,
  output logic                    busy
);

  localparam logic [ARB_CNT_W-1:0] QUANTUM_C = ARB_CNT_W'(QUANTUM);

  arbStateType          state;
  logic [1:0]           own;
  logic [1:0]           rr_ptr;
  logic [ARB_CNT_W-1:0] cnt;
  logic [N_REQ-1:0]     rd_pend;

  logic       in_hold, own_req, other_req, keep_own;
  logic [1:0] pick_start, pick_idx, win_idx;
  logic       pick_found, win_found, win_we;

  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i == int'(own)) own_req = req[i];
      else                other_req = other_req | req[i];
    end
  end

  assign in_hold    = (state == sHOLD);
  // The owner keeps the bus until its quantum is spent, unless nobody else waits.
  assign keep_own   = in_hold && own_req && ((cnt < QUANTUM_C) || !other_req);
  assign pick_start = in_hold ? next_idx(own, N_REQ) : rr_ptr;

  rr_pick #(.N(N_REQ)) u_pick (
    .req      (req),
    .start    (pick_start),
    .excl_en  (in_hold),
    .excl_idx (own),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign win_found = !rst && (keep_own || pick_found);
  assign win_idx   = keep_own ? own : pick_idx;

  always_comb begin
    gnt         = '0;
    win_we      = 1'b0;
    mem_address = '0;
    mem_dataW   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_found && int'(win_idx) == i) begin
        gnt[i]      = 1'b1;
        win_we      = we_i[i];
        mem_address = addr_i[i*ADDR_W +: ADDR_W];
        mem_dataW   = wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign mem_ce = win_found;
  assign mem_we = win_we;

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge ck) begin
    if (rst) begin
      state   <= sIDLE;
      own     <= '0;
      cnt     <= '0;
      rr_ptr  <= '0;
      rd_pend <= '0;
    end else if (win_found) begin
      state   <= sHOLD;
      cnt     <= (in_hold && win_idx == own) ? sat_inc(cnt) : ARB_CNT_W'(1);
      own     <= win_idx;
      rr_ptr  <= next_idx(win_idx, N_REQ);
      rd_pend <= win_we ? '0 : gnt;
    end else begin
      state   <= sIDLE;
      cnt     <= '0;
      rd_pend <= '0;
    end
  end

  // A reset arriving while a read is in flight drops its rvalid immediately.
  assign rvalid = rst ? '0 : rd_pend;
  assign rdata  = mem_dataR;
  assign owner  = own;
  assign busy   = in_hold && !rst;

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/reads, a negedge monitor
// pops and compares whenever the arbiter presents gnt or rvalid.
module tb_nano_mem_arbiter;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  // Instance A: two masters, quantum 4.
  logic        rst_a;
  logic [1:0]  req_a, we_a, gnt_a, rvalid_a, owner_a;
  logic [15:0] addr_a;
  logic [31:0] wdata_a;
  logic [15:0] rdata_a, mem_dataW_a, mem_dataR_a;
  logic        mem_ce_a, mem_we_a, busy_a;
  logic [7:0]  mem_address_a;

  // Instance B: three masters, used for the mid-operation reset case.
  logic        rst_b;
  logic [2:0]  req_b, we_b, gnt_b, rvalid_b;
  logic [1:0]  owner_b;
  logic [23:0] addr_b;
  logic [47:0] wdata_b;
  logic [15:0] rdata_b, mem_dataW_b, mem_dataR_b;
  logic        mem_ce_b, mem_we_b, busy_b;
  logic [7:0]  mem_address_b;

  nano_mem_arbiter #(.N_REQ(2), .QUANTUM(4)) dut_a (
    .ck(ck), .rst(rst_a), .req(req_a), .we_i(we_a), .addr_i(addr_a), .wdata_i(wdata_a),
    .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a), .mem_ce(mem_ce_a), .mem_we(mem_we_a),
    .mem_address(mem_address_a), .mem_dataW(mem_dataW_a), .mem_dataR(mem_dataR_a),
    .owner(owner_a), .busy(busy_a)
  );

  nano_mem_arbiter #(.N_REQ(3), .QUANTUM(4)) dut_b (
    .ck(ck), .rst(rst_b), .req(req_b), .we_i(we_b), .addr_i(addr_b), .wdata_i(wdata_b),
    .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .mem_ce(mem_ce_b), .mem_we(mem_we_b),
    .mem_address(mem_address_b), .mem_dataW(mem_dataW_b), .mem_dataR(mem_dataR_b),
    .owner(owner_b), .busy(busy_b)
  );

  // Memory macro with registered read; only instance A writes.
  logic [15:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[8'h12] = 16'hBEEF;
  end
  always @(posedge ck) begin
    if (mem_ce_a) begin
      if (mem_we_a) mem[mem_address_a] <= mem_dataW_a;
      else          mem_dataR_a <= mem[mem_address_a];
    end
    if (mem_ce_b && !mem_we_b) mem_dataR_b <= mem[mem_address_b];
  end

  typedef struct {
    logic [1:0]  gnt;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } gexp_t;

  typedef struct {
    logic [1:0]  rv;
    logic [15:0] data;
  } rexp_t;

  gexp_t q_g[$];
  rexp_t q_r[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_gnt(input int idx, input logic we, input logic [7:0] addr,
                            input logic [15:0] wdata);
    gexp_t e;
    e.gnt = 2'(1 << idx); e.we = we; e.addr = addr; e.wdata = wdata;
    q_g.push_back(e);
  endtask

  task automatic expect_rd(input int idx, input logic [15:0] data);
    rexp_t e;
    e.rv = 2'(1 << idx); e.data = data;
    q_r.push_back(e);
  endtask

  task automatic drive_a(input logic [1:0] r, input logic [1:0] w, input logic [7:0] a0,
                         input logic [7:0] a1, input logic [15:0] d0, input logic [15:0] d1);
    req_a = r; we_a = w; addr_a = {a1, a0}; wdata_a = {d1, d0};
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  // Monitor for instance A.
  always @(negedge ck) begin
    gexp_t ge;
    rexp_t re;
    if (gnt_a !== 2'b00) begin
      if (q_g.size() == 0) check("unexpected_gnt", 32'(gnt_a), 32'h0);
      else begin
        ge = q_g.pop_front();
        check("gnt", 32'(gnt_a), 32'(ge.gnt));
        check("mem_ce", 32'(mem_ce_a), 32'h1);
        check("mem_we", 32'(mem_we_a), 32'(ge.we));
        check("mem_address", 32'(mem_address_a), 32'(ge.addr));
        if (ge.we) check("mem_dataW", 32'(mem_dataW_a), 32'(ge.wdata));
      end
    end else begin
      check("idle_mem_ce", 32'(mem_ce_a), 32'h0);
    end
    if (rvalid_a !== 2'b00) begin
      if (q_r.size() == 0) check("unexpected_rvalid", 32'(rvalid_a), 32'h0);
      else begin
        re = q_r.pop_front();
        check("rvalid", 32'(rvalid_a), 32'(re.rv));
        check("rdata", 32'(rdata_a), 32'(re.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    drive_a(2'b11, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
    repeat (2) step();

    // Reset state, with requests asserted to show gnt is held off.
    @(negedge ck);
    check("rst_gnt", 32'(gnt_a), 32'h0);
    check("rst_mem_ce", 32'(mem_ce_a), 32'h0);
    check("rst_rvalid", 32'(rvalid_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_owner", 32'(owner_a), 32'h0);
    step();
    rst_a = 1'b0;

    // Simultaneous first requests: master 0 wins, then rotation favours master 1.
    drive_a(2'b11, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0);
    expect_gnt(0, 1'b0, 8'h01, 16'h0); expect_rd(0, 16'h1001);
    step();
    drive_a(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);
    @(negedge ck);
    check("t5_owner", 32'(owner_a), 32'h0);
    check("t5_busy", 32'(busy_a), 32'h1);
    step();
    drive_a(2'b11, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0);
    expect_gnt(1, 1'b0, 8'h02, 16'h0); expect_rd(1, 16'h1002);
    step();
    drive_a(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);
    step();

    // Single read by master 0.
    drive_a(2'b01, 2'b00, 8'h12, 8'h00, 16'h0, 16'h0);
    expect_gnt(0, 1'b0, 8'h12, 16'h0); expect_rd(0, 16'hBEEF);
    step();
    drive_a(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);
    step();
    @(negedge ck);
    check("t1_rvalid_T2", 32'(rvalid_a), 32'h0);
    check("t1_busy_T2", 32'(busy_a), 32'h0);
    step();

    // Write by master 1, read back by master 0.
    drive_a(2'b10, 2'b10, 8'h00, 8'h40, 16'h0, 16'h5A5A);
    expect_gnt(1, 1'b1, 8'h40, 16'h5A5A);
    step();
    drive_a(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);
    @(negedge ck);
    check("t2_write_no_rvalid", 32'(rvalid_a), 32'h0);
    step();
    drive_a(2'b01, 2'b00, 8'h40, 8'h00, 16'h0, 16'h0);
    expect_gnt(0, 1'b0, 8'h40, 16'h0); expect_rd(0, 16'h5A5A);
    step();
    drive_a(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);
    step();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;

    // Both held: quantum of 4 then rotation.
    for (int k = 0; k < 12; k++) begin
      int w;
      w = (k / 4) % 2;
      drive_a(2'b11, 2'b00, 8'h20, 8'h30, 16'h0, 16'h0);
      expect_gnt(w, 1'b0, (w == 1) ? 8'h30 : 8'h20, 16'h0);
      expect_rd(w, (w == 1) ? 16'h1030 : 16'h1020);
      @(negedge ck);
      if (k > 0) begin
        check("t3_owner", 32'(owner_a), 32'(((k - 1) / 4) % 2));
        check("t3_busy", 32'(busy_a), 32'h1);
      end
      step();
    end
    drive_a(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);
    @(negedge ck);
    check("t3_owner_last", 32'(owner_a), 32'h0);
    step();

    // Master 0 alone for 18 writes (counter saturates), then master 1 cuts in.
    for (int k = 0; k < 20; k++) begin
      if (k == 18) begin
        drive_a(2'b11, 2'b01, 8'(8'h60 + k), 8'h12, 16'(16'hA000 + k), 16'h0);
        expect_gnt(1, 1'b0, 8'h12, 16'h0); expect_rd(1, 16'hBEEF);
      end else begin
        drive_a(2'b01, 2'b01, 8'(8'h60 + k), 8'h12, 16'(16'hA000 + k), 16'h0);
        expect_gnt(0, 1'b1, 8'(8'h60 + k), 16'(16'hA000 + k));
      end
      step();
    end
    drive_a(2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);
    step();
    step();

    // Three masters: reset lands on the cycle the read data would return.
    rst_b = 1'b0;
    req_b = 3'b100; we_b = 3'b000; addr_b = {8'h12, 8'h00, 8'h00};
    @(negedge ck);
    check("t6_gnt_T", 32'(gnt_b), 32'h4);
    check("t6_addr_T", 32'(mem_address_b), 32'h12);
    step();
    rst_b = 1'b1; req_b = 3'b111;
    @(negedge ck);
    check("t6_rvalid_T1", 32'(rvalid_b), 32'h0);
    check("t6_gnt_rst", 32'(gnt_b), 32'h0);
    check("t6_busy_rst", 32'(busy_b), 32'h0);
    check("t6_mem_ce_rst", 32'(mem_ce_b), 32'h0);
    step();
    rst_b = 1'b0; req_b = 3'b000;
    @(negedge ck);
    check("t6_rvalid_T2", 32'(rvalid_b), 32'h0);
    check("t6_owner_after_rst", 32'(owner_b), 32'h0);
    step();
    req_b = 3'b110; addr_b = {8'h12, 8'h30, 8'h00};
    @(negedge ck);
    check("t6_restart_gnt", 32'(gnt_b), 32'h2);
    step();
    req_b = 3'b000;
    @(negedge ck);
    check("t6_restart_rvalid", 32'(rvalid_b), 32'h2);
    check("t6_restart_rdata", 32'(rdata_b), 32'h1030);
    step();

    check("gnt_queue_drained", 32'(q_g.size()), 32'h0);
    check("rd_queue_drained", 32'(q_r.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
